// File: rtl/scope_trigger_capture_pkg.sv
// Shared state encoding and default sizing for the triggered scope capture core.
package scope_trigger_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_WAIT,
        ST_POST,
        ST_READ
    } state_e;

    localparam int DEF_DATA_W       = 8;
    localparam int DEF_DEPTH        = 256;
    localparam int DEF_ADDR_W       = 8;
    localparam int DEF_DECIM_W      = 8;
    localparam int DEF_AUTO_TIMEOUT = 1000000;

endpackage

// File: rtl/scope_trigger_capture_sample_ram.sv
// Simple dual-port capture buffer: synchronous write, registered read (maps onto ice40 EBR).
module scope_trigger_capture_sample_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iWr_En,
    input  logic [ADDR_W-1:0] iWr_Addr,
    input  logic [DATA_W-1:0] iWr_Data,
    input  logic              iRd_En,
    input  logic [ADDR_W-1:0] iRd_Addr,
    output logic [DATA_W-1:0] oRd_Data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // NOTE: the array has no reset so it stays in block RAM; only the read register is reset.
    always_ff @(posedge iClk) begin
        if (iWr_En) mem[iWr_Addr] <= iWr_Data;
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n)     rd_data_q <= '0;
        else if (iRd_En) rd_data_q <= mem[iRd_Addr];
    end

    assign oRd_Data = rd_data_q;

endmodule

// File: rtl/scope_trigger_capture.sv
// Armed, triggered capture core with decimation, pre-trigger history and valid/ready readout.
// Optional forced trigger after a WAIT_TRIG timeout is enabled by defining SCOPE_AUTOTRIG_EN.
module scope_trigger_capture
    import scope_trigger_capture_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DECIM_W      = DEF_DECIM_W,
    parameter int AUTO_TIMEOUT = DEF_AUTO_TIMEOUT
) (
    input  logic               iClk,
    input  logic               iRst_n,
    input  logic               iArm,
    input  logic [DECIM_W-1:0] iDecim,
    input  logic [DATA_W-1:0]  iTrigLevel,
    input  logic               iTrigRising,
    input  logic [ADDR_W-1:0]  iPreTrig,
    input  logic [DATA_W-1:0]  iData,
    input  logic               iData_Valid,
    output logic [DATA_W-1:0]  oData,
    output logic               oData_Valid,
    input  logic               iData_Ready,
    output logic               oBusy,
    output logic               oTriggered,
    output logic               oAutoTrig
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e             state_q;
    logic [DECIM_W-1:0] decim_q, decim_cnt_q;
    logic [DATA_W-1:0]  level_q, prev_q;
    logic               rising_q, prev_valid_q;
    logic [ADDR_W-1:0]  pre_q, rem_q, wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]    rd_left_q;
    logic               out_valid_q, triggered_q;

    logic capturing, keep, crossed, force_trig, fire, rd_en;

    assign capturing = (state_q == ST_PRE) || (state_q == ST_WAIT) || (state_q == ST_POST);
    assign keep      = capturing && iData_Valid && (decim_cnt_q == '0);
    assign crossed   = prev_valid_q &&
                       (rising_q ? (prev_q < level_q && iData >= level_q)
                                 : (prev_q > level_q && iData <= level_q));
    assign fire      = (state_q == ST_WAIT) && keep && (crossed || force_trig);
    // The RAM read register doubles as the output register, so a read may issue whenever it drains.
    assign rd_en     = (state_q == ST_READ) && (rd_left_q != '0) && (!out_valid_q || iData_Ready);

`ifdef SCOPE_AUTOTRIG_EN
    localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);

    logic [TO_W-1:0] wait_cnt_q;
    logic            auto_q;

    assign force_trig = (wait_cnt_q == TO_W'(AUTO_TIMEOUT));

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n)                          wait_cnt_q <= '0;
        else if (iArm || state_q != ST_WAIT)  wait_cnt_q <= '0;
        else if (!force_trig)                 wait_cnt_q <= wait_cnt_q + 1'b1;
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n)   auto_q <= 1'b0;
        else if (iArm) auto_q <= 1'b0;
        else if (fire) auto_q <= force_trig;
    end

    assign oAutoTrig = auto_q;
`else
    localparam int unused_auto_timeout = AUTO_TIMEOUT;

    assign force_trig = 1'b0;
    assign oAutoTrig  = 1'b0;
`endif

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q      <= ST_IDLE;
            decim_q      <= '0;
            decim_cnt_q  <= '0;
            level_q      <= '0;
            prev_q       <= '0;
            rising_q     <= 1'b0;
            prev_valid_q <= 1'b0;
            pre_q        <= '0;
            rem_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rd_left_q    <= '0;
            out_valid_q  <= 1'b0;
            triggered_q  <= 1'b0;
        end else if (iArm) begin
            decim_q      <= iDecim;
            level_q      <= iTrigLevel;
            rising_q     <= iTrigRising;
            pre_q        <= iPreTrig;
            rem_q        <= iPreTrig;
            wr_ptr_q     <= '0;
            decim_cnt_q  <= '0;
            prev_valid_q <= 1'b0;
            triggered_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            state_q      <= (iPreTrig == '0) ? ST_WAIT : ST_PRE;
        end else begin
            if (capturing && iData_Valid)
                decim_cnt_q <= (decim_cnt_q == decim_q) ? '0 : decim_cnt_q + 1'b1;
            if (keep) begin
                wr_ptr_q     <= wr_ptr_q + 1'b1;
                prev_q       <= iData;
                prev_valid_q <= 1'b1;
            end
            case (state_q)
                ST_PRE: if (keep) begin
                    rem_q <= rem_q - 1'b1;
                    if (rem_q == ADDR_W'(1)) state_q <= ST_WAIT;
                end
                // Readout start (oldest history first) is fixed here, from the trigger sample's address.
                ST_WAIT: if (fire) begin
                    triggered_q <= 1'b1;
                    rd_ptr_q    <= wr_ptr_q - pre_q;
                    rd_left_q   <= (ADDR_W + 1)'(DEPTH);
                    rem_q       <= LAST_ADDR - pre_q;
                    state_q     <= (pre_q == LAST_ADDR) ? ST_READ : ST_POST;
                end
                ST_POST: if (keep) begin
                    rem_q <= rem_q - 1'b1;
                    if (rem_q == ADDR_W'(1)) state_q <= ST_READ;
                end
                ST_READ: begin
                    if (rd_en) begin
                        rd_ptr_q    <= rd_ptr_q + 1'b1;
                        rd_left_q   <= rd_left_q - 1'b1;
                        out_valid_q <= 1'b1;
                    end else if (out_valid_q && iData_Ready) begin
                        out_valid_q <= 1'b0;
                        if (rd_left_q == '0) state_q <= ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    scope_trigger_capture_sample_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .iClk     (iClk),
        .iRst_n   (iRst_n),
        .iWr_En   (keep),
        .iWr_Addr (wr_ptr_q),
        .iWr_Data (iData),
        .iRd_En   (rd_en),
        .iRd_Addr (rd_ptr_q),
        .oRd_Data (oData)
    );

    assign oData_Valid = out_valid_q;
    assign oBusy       = (state_q != ST_IDLE);
    assign oTriggered  = triggered_q;

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Self-checking bench: directed ramps plus randomized captures against a sample-list reference model.
module tb_scope_trigger_capture;

    localparam int DEPTH = 16;

    logic       iClk = 1'b0;
    logic       iRst_n = 1'b0;
    logic       iArm = 1'b0;
    logic [7:0] iDecim = '0;
    logic [7:0] iTrigLevel = '0;
    logic       iTrigRising = 1'b0;
    logic [3:0] iPreTrig = '0;
    logic [7:0] iData = '0;
    logic       iData_Valid = 1'b0;
    logic       iData_Ready = 1'b0;
    logic [7:0] oData;
    logic       oData_Valid, oBusy, oTriggered, oAutoTrig;

    scope_trigger_capture #(
        .DATA_W       (8),
        .DEPTH        (DEPTH),
        .ADDR_W       (4),
        .DECIM_W      (8),
        .AUTO_TIMEOUT (50)
    ) dut (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .iArm        (iArm),
        .iDecim      (iDecim),
        .iTrigLevel  (iTrigLevel),
        .iTrigRising (iTrigRising),
        .iPreTrig    (iPreTrig),
        .iData       (iData),
        .iData_Valid (iData_Valid),
        .oData       (oData),
        .oData_Valid (oData_Valid),
        .iData_Ready (iData_Ready),
        .oBusy       (oBusy),
        .oTriggered  (oTriggered),
        .oAutoTrig   (oAutoTrig)
    );

    always #5 iClk = ~iClk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] stream_q[$];
    int         s_idx = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: keep every (decim+1)th fed sample, find the first qualifying crossing at or after
    // kept index pre, and return the DEPTH kept samples starting pre samples before it.
    function automatic bit model(input int decim, input logic [7:0] level, input bit rising,
                                 input int pre, output logic [7:0] exp[$], output int wait_kept);
        logic [7:0] kept[$];
        exp = {};
        wait_kept = -1;
        for (int i = 0; i < stream_q.size(); i += decim + 1) kept.push_back(stream_q[i]);
        for (int k = pre; k < kept.size(); k++) begin
            bit hit;
            hit = (k > 0) && (rising ? (kept[k-1] < level && kept[k] >= level)
                                     : (kept[k-1] > level && kept[k] <= level));
            if (hit) begin
                if (k - pre + DEPTH > kept.size()) return 0;
                for (int j = 0; j < DEPTH; j++) exp.push_back(kept[k-pre+j]);
                wait_kept = k - pre;
                return 1;
            end
        end
        return 0;
    endfunction

    task automatic do_arm(input int decim, input logic [7:0] level, input bit rising, input int pre);
        @(negedge iClk);
        iDecim = 8'(decim);
        iTrigLevel = level;
        iTrigRising = rising;
        iPreTrig = 4'(pre);
        iArm = 1'b1;
        iData_Valid = 1'b0;
        iData_Ready = 1'b1;
        @(posedge iClk);
        #1;
        iArm = 1'b0;
        // Config must be latched at arm, so scramble it afterwards.
        iDecim = 8'($urandom);
        iTrigLevel = 8'($urandom);
        iTrigRising = 1'($urandom);
        iPreTrig = 4'($urandom);
        s_idx = 0;
    endtask

    task automatic feed(input int n, output bit saw_valid);
        saw_valid = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge iClk);
            if (oData_Valid === 1'b1) saw_valid = 1'b1;
            iData_Ready = 1'b1;
            iData_Valid = (s_idx < stream_q.size());
            iData = iData_Valid ? stream_q[s_idx] : 8'($urandom);
            if (iData_Valid) s_idx++;
        end
    endtask

    task automatic run_capture(input string tag, input int vmode, input int rmode,
                               input logic [7:0] exp[$], input int stop_after, input logic exp_auto);
        int         beats = 0;
        int         cyc = 0;
        logic       lv = 1'b0, lr = 1'b0, rdy, vld;
        logic [7:0] ld = '0;
        forever begin
            @(negedge iClk);
            if (oBusy !== 1'b1 || cyc >= 4000) break;
            if (stop_after >= 0 && beats >= stop_after) break;
            if (lv && !lr) begin
                check({tag, "_hold_valid"}, 32'(oData_Valid), 32'(1));
                check({tag, "_hold_data"}, 32'(oData), 32'(ld));
            end
            vld = (vmode == 0) ? 1'b1 : ($urandom_range(0, 7) != 0);
            if (s_idx >= stream_q.size()) vld = 1'b0;
            iData_Valid = vld;
            iData = vld ? stream_q[s_idx] : 8'($urandom);
            if (vld) s_idx++;
            case (rmode)
                1:       rdy = (cyc % 2 == 0);
                2:       rdy = 1'($urandom_range(0, 1));
                3:       rdy = ((cyc / 12) % 3 == 2) ? 1'b0 : (cyc % 2 == 0);
                default: rdy = 1'b1;
            endcase
            iData_Ready = rdy;
            if (oData_Valid === 1'b1 && rdy) begin
                if (beats < exp.size()) check($sformatf("%s_beat%0d", tag, beats), 32'(oData), 32'(exp[beats]));
                beats++;
            end
            lv = oData_Valid;
            lr = rdy;
            ld = oData;
            cyc++;
        end
        iData_Valid = 1'b0;
        if (stop_after < 0) begin
            check({tag, "_idle"}, 32'(oBusy), 32'(0));
            check({tag, "_beats"}, 32'(beats), 32'(exp.size()));
            check({tag, "_triggered"}, 32'(oTriggered), 32'(1));
            check({tag, "_autotrig"}, 32'(oAutoTrig), 32'(exp_auto));
        end
    endtask

    task automatic gen_random(input int decim, input logic [7:0] level, input bit rising,
                              input int pre, output logic [7:0] exp[$]);
        int  wk;
        bit  ok = 1'b0;
        for (int t = 0; t < 10000 && !ok; t++) begin
            stream_q = {};
            for (int i = 0; i < 200; i++) stream_q.push_back(8'($urandom));
            ok = model(decim, level, rising, pre, exp, wk) && (wk <= 4);
        end
        check("gen_random_found", 32'(ok), 32'(1));
    endtask

    task automatic random_capture(input string tag, input int decim, input int pre,
                                  input int vmode, input int rmode);
        logic [7:0] exp[$];
        logic [7:0] level;
        bit         rising;
        level = 8'($urandom_range(8'h40, 8'hC0));
        rising = 1'($urandom);
        gen_random(decim, level, rising, pre, exp);
        do_arm(decim, level, rising, pre);
        run_capture(tag, vmode, rmode, exp, -1, 1'b0);
    endtask

    initial begin
        logic [7:0] exp[$];
        int         wk;
        bit         ok, saw;

        // Reset state
        repeat (3) @(negedge iClk);
        check("rst_busy", 32'(oBusy), 32'(0));
        check("rst_valid", 32'(oData_Valid), 32'(0));
        check("rst_data", 32'(oData), 32'(0));
        check("rst_triggered", 32'(oTriggered), 32'(0));
        check("rst_autotrig", 32'(oAutoTrig), 32'(0));
        iRst_n = 1'b1;

        // Rising ramp, no decimation, 4 pre-trigger samples
        stream_q = {};
        for (int i = 0; i < 40; i++) stream_q.push_back(8'(i * 16));
        ok = model(0, 8'h80, 1'b1, 4, exp, wk);
        check("ramp_rise_model", 32'(ok), 32'(1));
        do_arm(0, 8'h80, 1'b1, 4);
        run_capture("ramp_rise", 0, 0, exp, -1, 1'b0);

        // Falling ramp with 1-in-4 decimation and gappy valid
        stream_q = {};
        for (int i = 0; i < 150; i++) stream_q.push_back(8'(8'h38 - i));
        ok = model(3, 8'h20, 1'b0, 4, exp, wk);
        check("ramp_fall_model", 32'(ok), 32'(1));
        do_arm(3, 8'h20, 1'b0, 4);
        run_capture("ramp_fall_decim", 1, 0, exp, -1, 1'b0);

        // Backpressure patterns
        random_capture("bp_toggle", 0, 6, 0, 1);
        random_capture("bp_burst", 1, 3, 1, 3);
        random_capture("bp_random", 2, 8, 1, 2);

        // Pre-trigger boundaries
        random_capture("pre_zero", 1, 0, 1, 0);
        random_capture("pre_max", 0, 15, 0, 2);

        // Randomized configurations
        for (int r = 0; r < 4; r++)
            random_capture($sformatf("rand%0d", r), $urandom_range(0, 3), $urandom_range(0, 15), 1, 2);

        // Re-arm mid-READ
        gen_random(1, 8'h80, 1'b1, 5, exp);
        do_arm(1, 8'h80, 1'b1, 5);
        run_capture("abort_read_first", 0, 1, exp, 5, 1'b0);
        gen_random(0, 8'h60, 1'b0, 7, exp);
        do_arm(0, 8'h60, 1'b0, 7);
        check("abort_read_valid", 32'(oData_Valid), 32'(0));
        check("abort_read_triggered", 32'(oTriggered), 32'(0));
        run_capture("abort_read_second", 1, 2, exp, -1, 1'b0);

        // Re-arm while waiting for a trigger that never comes
        stream_q = {};
        for (int i = 0; i < 60; i++) stream_q.push_back(8'h10);
        do_arm(0, 8'h80, 1'b1, 2);
        feed(20, saw);
        check("abort_wait_busy", 32'(oBusy), 32'(1));
        check("abort_wait_triggered", 32'(oTriggered), 32'(0));
        random_capture("abort_wait_second", 2, 9, 1, 0);

        // Flat input: forced trigger only when the timeout feature is built in
        stream_q = {};
        for (int i = 0; i < 2000; i++) stream_q.push_back(8'h10);
        do_arm(0, 8'h80, 1'b1, 4);
`ifdef SCOPE_AUTOTRIG_EN
        exp = {};
        for (int i = 0; i < DEPTH; i++) exp.push_back(8'h10);
        run_capture("autotrig", 0, 0, exp, -1, 1'b1);
`else
        feed(1000, saw);
        check("no_autotrig_busy", 32'(oBusy), 32'(1));
        check("no_autotrig_triggered", 32'(oTriggered), 32'(0));
        check("no_autotrig_flag", 32'(oAutoTrig), 32'(0));
        check("no_autotrig_valid", 32'(saw), 32'(0));
`endif

        // Reset while in POST
        stream_q = {};
        for (int i = 0; i < 40; i++) stream_q.push_back(8'(i * 16));
        do_arm(0, 8'h80, 1'b1, 4);
        for (int c = 0; c < 100 && oTriggered !== 1'b1; c++) feed(1, saw);
        check("post_rst_pre_trig", 32'(oTriggered), 32'(1));
        feed(2, saw);
        @(negedge iClk);
        #2;
        iRst_n = 1'b0;
        #1;
        check("post_rst_busy", 32'(oBusy), 32'(0));
        check("post_rst_valid", 32'(oData_Valid), 32'(0));
        check("post_rst_triggered", 32'(oTriggered), 32'(0));
        @(negedge iClk);
        iRst_n = 1'b1;
        feed(40, saw);
        check("post_rst_no_readout", 32'(saw), 32'(0));
        check("post_rst_idle", 32'(oBusy), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
